// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and default widths for the serial stream controller.
package seq_ctrl_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_word_shifter.sv
// Parallel-load shift register that presents one word MSB first and flags its final bit.
module seq_word_shifter
  import seq_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word_in,
  output logic              msb,
  output logic              last_bit
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg_reg;
  logic [IDX_W-1:0]  idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg <= '0;
      idx_reg   <= '0;
    end else if (load) begin
      shreg_reg <= word_in;
      idx_reg   <= '0;
    end else if (shift) begin
      shreg_reg <= shreg_reg << 1;
      idx_reg   <= idx_reg + 1'b1;
    end
  end

  assign msb      = shreg_reg[WORD_W-1];
  assign last_bit = (idx_reg == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/seq_stream_ctrl.sv
// Feeds words bit-serially into an external pattern detector and counts its matches per run.
module seq_stream_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  input  logic [CNT_W-1:0]  count_limit,
  output logic              det_bit,
  output logic              det_rst,
  input  logic              det_match,
  output logic [CNT_W-1:0]  match_count,
  output logic              limit_hit,
  output logic              busy,
  output logic              done
);

  state_t           state_reg, state_next;
  logic             last_reg, last_next;
  logic             bit_vld_d_reg;
  logic [CNT_W-1:0] match_count_reg;
  logic             limit_hit_reg;
  logic             load, shift, msb, last_bit, clear_run;

  seq_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .word_in  (word_in),
    .msb      (msb),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    load       = 1'b0;
    shift      = 1'b0;
    clear_run  = 1'b0;
    word_ready = 1'b0;
    det_bit    = 1'b0;
    det_rst    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          clear_run  = 1'b1;
          det_rst    = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        word_ready = 1'b1;
        det_rst    = 1'b1;
        if (word_valid) begin
          load       = 1'b1;
          last_next  = word_last;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        det_bit = msb;
        if (!last_bit) begin
          shift = 1'b1;
        end else if (last_reg) begin
          state_next = S_DRAIN;
        end else begin
          // Accepting here keeps the bit stream contiguous across words.
          word_ready = 1'b1;
          if (word_valid) begin
            load      = 1'b1;
            last_next = word_last;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) begin
      load       = 1'b0;
      shift      = 1'b0;
      clear_run  = 1'b0;
      word_ready = 1'b0;
      det_bit    = 1'b0;
      det_rst    = 1'b1;
      done       = 1'b0;
    end
  end

  // The detector answers one cycle after its bit, so qualify with a delayed SHIFT flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_vld_d_reg   <= 1'b0;
      match_count_reg <= '0;
      limit_hit_reg   <= 1'b0;
    end else begin
      bit_vld_d_reg <= (state_reg == S_SHIFT);
      if (clear_run) begin
        match_count_reg <= '0;
        limit_hit_reg   <= 1'b0;
      end else begin
        if (det_match && bit_vld_d_reg && (match_count_reg != '1))
          match_count_reg <= match_count_reg + 1'b1;
        if ((count_limit != '0) && (match_count_reg >= count_limit))
          limit_hit_reg <= 1'b1;
      end
    end
  end

  assign match_count = match_count_reg;
  assign limit_hit   = limit_hit_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl with a behavioural "101" overlapping detector.
module tb_seq_stream_ctrl;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_last = 1'b0;
  logic [CW-1:0] count_limit = '0;
  logic          word_ready, det_bit, det_rst, det_match, limit_hit, busy, done;
  logic [CW-1:0] match_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .WORD_W (W),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_last   (word_last),
    .word_ready  (word_ready),
    .count_limit (count_limit),
    .det_bit     (det_bit),
    .det_rst     (det_rst),
    .det_match   (det_match),
    .match_count (match_count),
    .limit_hit   (limit_hit),
    .busy        (busy),
    .done        (done)
  );

  // External detector: registered, overlapping "101".
  logic [1:0] det_hist = '0;
  logic       det_match_r = 1'b0;
  always @(posedge clk) begin
    if (det_rst) begin
      det_hist    <= '0;
      det_match_r <= 1'b0;
    end else begin
      det_hist    <= {det_hist[0], det_bit};
      det_match_r <= ({det_hist, det_bit} == 3'b101);
    end
  end
  assign det_match = det_match_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  bit  bit_q[$];
  int  cnt_q[$];
  int  lim_q[$];
  int  load_q[$];
  int  bits_left = 0;
  int  drain_ctr = 0;
  int  load_ctr = 0;
  int  run_no = 0;
  bit  lim_probe = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      bit_q.delete();
      bits_left = 0;
      load_ctr  = 0;
      drain_ctr = 100;
    end else begin
      if (drain_ctr < 100) drain_ctr++;
      if (word_ready && det_rst) load_ctr++;
      if (bits_left > 0) begin
        if (bit_q.size() > 0) check("det_bit", det_bit, bit_q.pop_front());
        else check("bit_queue_empty", 0, 1);
        if (lim_probe && bits_left == 2) check("limit_early", limit_hit, 0);
        if (lim_probe && bits_left == 1) check("limit_rise", limit_hit, 1);
        bits_left--;
        if (bits_left == 0) drain_ctr = 0;
      end
      if (word_valid && word_ready) begin
        bits_left += W;
        for (int b = W - 1; b >= 0; b--) bit_q.push_back(word_in[b]);
      end
      if (done) begin
        check("done_latency", drain_ctr, 2);
        if (cnt_q.size() > 0) begin
          int ec, el, eld;
          ec  = cnt_q.pop_front();
          el  = lim_q.pop_front();
          eld = load_q.pop_front();
          check("match_count", match_count, ec);
          check("limit_hit", limit_hit, el);
          check("load_cycles", load_ctr, eld);
          $display("run %0d: match_count=%0d (exp %0d) limit_hit=%0d (exp %0d) load_cycles=%0d (exp %0d)",
                   run_no, match_count, ec, limit_hit, el, load_ctr, eld);
          run_no++;
        end else begin
          check("unexpected_done", 1, 0);
        end
        load_ctr = 0;
      end
    end
  end

  logic [W-1:0] stim_w[80];
  int           stim_gap[80];

  // stim_gap[i] < 0: word i follows back-to-back; >= 0: valid stays low that many cycles past the last bit.
  task automatic do_run(input int n, input int lim, input bit hold_start);
    int ec, eloads, el, to;
    logic [2:0] h;
    ec = 0; eloads = 1; h = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && stim_gap[i] >= 0) begin
        h = '0;
        eloads += stim_gap[i] + 1;
      end
      for (int b = W - 1; b >= 0; b--) begin
        h = {h[1:0], stim_w[i][b]};
        if (h == 3'b101) ec++;
      end
    end
    if (ec > (1 << CW) - 1) ec = (1 << CW) - 1;
    el = (lim != 0 && ec >= lim) ? 1 : 0;
    cnt_q.push_back(ec);
    lim_q.push_back(el);
    load_q.push_back(eloads);

    count_limit = CW'(lim);
    start = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && stim_gap[i] >= 0) begin
        word_valid = 1'b0;
        repeat (W + stim_gap[i]) @(posedge clk);
        #1;
      end
      word_in    = stim_w[i];
      word_last  = (i == n - 1);
      word_valid = 1'b1;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!word_ready && to < 40);
      if (!word_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    start      = 1'b0;
    to = 0;
    while (!done && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    check("count_hold", match_count, ec);
    check("limit_hold", limit_hit, el);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_det_rst", det_rst, 1);
    check("rst_word_ready", word_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_count", match_count, 0);
    check("idle_limit", limit_hit, 0);
    check("idle_done", done, 0);
    check("idle_det_rst", det_rst, 0);

    stim_w[0] = 8'hAA; stim_gap[0] = -1;
    do_run(1, 0, 1'b0);

    stim_w[0] = 8'hFF;
    do_run(1, 1, 1'b0);

    stim_w[0] = 8'h0A; stim_w[1] = 8'hA0; stim_gap[1] = -1;
    do_run(2, 0, 1'b1);

    stim_gap[1] = 2;
    do_run(2, 0, 1'b0);

    stim_w[0] = 8'hAA;
    lim_probe = 1'b1;
    do_run(1, 2, 1'b0);
    lim_probe = 1'b0;

    // Reset in the middle of shifting a word.
    count_limit = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    word_in = 8'hAA; word_last = 1'b1; word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0; word_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_word_ready", word_ready, 0);
    check("midrst_det_bit", det_bit, 0);
    check("midrst_done", done, 0);
    check("midrst_det_rst", det_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", busy, 0);
    check("postrst_count", match_count, 0);
    check("postrst_limit", limit_hit, 0);
    check("postrst_det_bit", det_bit, 0);
    check("postrst_word_ready", word_ready, 0);

    stim_w[0] = 8'hAA;
    do_run(1, 3, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        stim_w[i]   = W'($urandom_range(0, 255));
        stim_gap[i] = int'($urandom_range(0, 2)) - 1;
      end
      do_run(3, int'($urandom_range(0, 4)), 1'b0);
    end

    // Long contiguous stream drives the counter into saturation.
    for (int i = 0; i < 70; i++) begin
      stim_w[i]   = 8'hAA;
      stim_gap[i] = -1;
    end
    do_run(70, 255, 1'b0);

    check("scoreboard_drained", cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_stream_ctrl.md
SEQ_STREAM_CTRL -- requirements
Module: seq_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per input word.
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a run; sampled in IDLE only.
REQ-006 SHALL have port word_in  input  WORD_W  word to serialise, MSB first.
REQ-007 SHALL have port word_valid  input  1  word_in/word_last valid.
REQ-008 SHALL have port word_last  input  1  current word ends the run.
REQ-009 SHALL have port word_ready  output  1  controller accepts word this cycle.
REQ-010 SHALL have port count_limit  input  CNT_W  match threshold; 0 disables.
REQ-011 SHALL have port det_bit  output  1  serial bit to the pattern detector data_in.
REQ-012 SHALL have port det_rst  output  1  synchronous clear to the detector.
REQ-013 SHALL have port det_match  input  1  detector out (registered, one cycle after its bit).
REQ-014 SHALL have port match_count  output  CNT_W  matches counted this run.
REQ-015 SHALL have port limit_hit  output  1  sticky: match_count >= count_limit, count_limit != 0.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-018 SHALL implement FSM IDLE, LOAD, SHIFT, DRAIN, DONE.
REQ-019 IDLE & start: clear match_count and limit_hit, pulse det_rst one cycle, -> LOAD; start while busy SHALL be ignored.
REQ-020 LOAD: word_ready=1, det_rst=1, det_bit=0; word_valid -> capture word and last flag, -> SHIFT.
REQ-021 SHIFT: drive det_bit = captured word MSB first, one bit per cycle, WORD_W cycles, det_rst=0.
REQ-022 Last SHIFT cycle: word_ready=1; word_valid and captured last flag clear -> load next word, next cycle drives its MSB (no gap, detector context preserved).
REQ-023 Last SHIFT cycle, no word_valid, last flag clear -> LOAD (gap resets detector context per REQ-020).
REQ-024 Last SHIFT cycle, captured last flag set -> DRAIN; word_ready=0 then.
REQ-025 DRAIN: one cycle, det_bit=0, det_rst=0 -> DONE; DONE: done=1 one cycle -> IDLE.
REQ-026 bit_vld_d SHALL be a one-cycle-delayed copy of "SHIFT active"; match_count increments when det_match & bit_vld_d.
REQ-027 match_count SHALL saturate at 2^CNT_W-1.
REQ-028 limit_hit SHALL set the cycle after match_count first reaches count_limit and hold until next accepted start.
REQ-029 match_count and limit_hit SHALL hold after DONE until next accepted start.
REQ-030 word_ready SHALL be 0 in IDLE, DRAIN, DONE and in non-final SHIFT cycles.

Reset
REQ-031 rst SHALL, at any state including mid-SHIFT, force IDLE, match_count=0, limit_hit=0, done=0, word_ready=0, det_bit=0, det_rst=1 during rst, discarding any captured word.
REQ-032 First cycle after rst release SHALL accept start.

Structure
REQ-033 Package seq_ctrl_pkg SHALL hold state encoding enum and default WORD_W/CNT_W constants.
REQ-034 Sub-module seq_word_shifter SHALL hold the load/shift register and bit index, with load, shift, msb, last_bit outputs.
REQ-035 The pattern detector SHALL stay external; this block only drives/observes it.

Verification
REQ-036 start, word 0xAA last=1 -> det_bit 1,0,1,0,1,0,1,0; match_count=3; done one cycle after DRAIN.
REQ-037 start, word 0xFF last=1 -> match_count=0, limit_hit=0 (count_limit=1).
REQ-038 start, 0x0A then 0xA0 (last) back-to-back -> no LOAD between, match_count=3.
REQ-039 start, 0x0A, 2-cycle valid gap, 0xA0 (last) -> det_rst high in gap, match_count=2.
REQ-040 count_limit=2, word 0xAA -> limit_hit rises after 2nd match, holds through DONE; rst mid-SHIFT -> IDLE, all outputs zero, next start works.
